// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the program counter and runs a
//             req/ack handshake to instruction memory. It buffers a fetched
//             word while decode is stalled, and it cancels wrong-path fetches
//             when decode redirects the PC. It delivers rd/pcp4f to the
//             IF/ID register.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             stallf               - hazard-unit fetch stall
//             redirect/redirect_pc - taken branch/jump from decode
//             imem_req/imem_addr   - memory request (address held until ack)
//             imem_ack/imem_rdata  - single-cycle ack with read data
//             rd/pcp4f/fvalid      - instruction, PC+4 and valid to IF/ID
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallf,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] rd,
    output logic [31:0] pcp4f,
    output logic        fvalid
);

    localparam logic [1:0] c_FETCH   = 2'd0;
    localparam logic [1:0] c_HOLD    = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ins_q;
    logic [31:0] r_pcp4_q;
    logic [31:0] r_tgt_q;

    logic        w_in_fetch;
    logic        w_in_hold;
    logic        w_in_discard;
    logic [31:0] w_pcp4;
    logic [31:0] w_redir_pc;

    assign w_in_fetch   = (r_state == c_FETCH);
    assign w_in_hold    = (r_state == c_HOLD);
    assign w_in_discard = (r_state == c_DISCARD);
    assign w_pcp4       = r_pc + 32'd4;            // wraps modulo 2^32
    assign w_redir_pc   = {redirect_pc[31:2], 2'b00};

    // Gating with rst_n drops the request the instant reset asserts, and the
    // first request appears as soon as reset is released.
    assign imem_req  = rst_n & ~w_in_hold;
    assign imem_addr = r_pc;

    // Data is live in the ack cycle; no register stage on the read path.
    assign fvalid = ~redirect & ((w_in_fetch & imem_ack) | w_in_hold);
    assign rd     = fvalid ? (w_in_hold ? r_ins_q  : imem_rdata) : 32'd0;
    assign pcp4f  = fvalid ? (w_in_hold ? r_pcp4_q : w_pcp4)     : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_FETCH;
            r_pc     <= RESET_PC;
            r_ins_q  <= 32'd0;
            r_pcp4_q <= 32'd0;
            r_tgt_q  <= 32'd0;
        end else begin
            case (r_state)
                c_FETCH: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            r_pc <= w_redir_pc;
                        end else begin
                            r_pc <= w_pcp4;
                            if (stallf) begin
                                // IF/ID will not capture: park the word.
                                r_ins_q  <= imem_rdata;
                                r_pcp4_q <= w_pcp4;
                                r_state  <= c_HOLD;
                            end
                        end
                    end else if (redirect) begin
                        // Address must stay put until the ack, so remember
                        // the target and throw away the wrong-path data.
                        r_tgt_q <= w_redir_pc;
                        r_state <= c_DISCARD;
                    end
                end
                c_HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_redir_pc;
                        r_state <= c_FETCH;
                    end else if (!stallf) begin
                        r_state <= c_FETCH;
                    end
                end
                c_DISCARD: begin
                    if (redirect) begin
                        r_tgt_q <= w_redir_pc;
                    end
                    if (imem_ack) begin
                        // A redirect in the ack cycle is the newest target.
                        r_pc    <= redirect ? w_redir_pc : r_tgt_q;
                        r_state <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed scenarios followed
//             by randomized stall/redirect/memory-latency traffic, compared
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;

    logic        clk;
    logic        rst_n;
    logic        stallf;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] rd;
    logic [31:0] pcp4f;
    logic        fvalid;

    int tests;
    int fails;

    // Reference model: where the next fetch goes, whether a delivered word is
    // parked waiting for decode, and whether the outstanding request belongs
    // to a cancelled path (with the address to resume at).
    logic [31:0] m_pc;
    logic        m_holding;
    logic [31:0] m_held_ins;
    logic [31:0] m_held_p4;
    logic        m_wrong;
    logic [31:0] m_target;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallf      (stallf),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .rd          (rd),
        .pcp4f       (pcp4f),
        .fvalid      (fvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_holding  = 1'b0;
        m_held_ins = 32'd0;
        m_held_p4  = 32'd0;
        m_wrong    = 1'b0;
        m_target   = 32'd0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs
    // against the model, then advance the model to what the rising edge does.
    task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic a);
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] erd;
        logic [31:0] ep4;
        @(negedge clk);
        stallf      = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ack    = a & imem_req;     // memory only acks a live request
        imem_rdata  = $urandom;
        #1;
        tgt = {rp[31:2], 2'b00};
        ev  = !r && (m_holding || (!m_wrong && imem_ack));
        erd = !ev ? 32'd0 : (m_holding ? m_held_ins : imem_rdata);
        ep4 = !ev ? 32'd0 : (m_holding ? m_held_p4  : m_pc + 32'd4);
        chk("imem_req", 32'(imem_req), 32'(!m_holding));
        chk("imem_addr", imem_addr, m_pc);
        chk("fvalid", 32'(fvalid), 32'(ev));
        chk("rd", rd, erd);
        chk("pcp4f", pcp4f, ep4);

        if (m_holding) begin
            if (r) begin
                m_pc      = tgt;
                m_holding = 1'b0;
            end else if (!s) begin
                m_holding = 1'b0;
            end
        end else if (m_wrong) begin
            if (imem_ack) begin
                m_pc    = r ? tgt : m_target;
                m_wrong = 1'b0;
            end
            if (r) m_target = tgt;
        end else if (imem_ack) begin
            if (r) begin
                m_pc = tgt;
            end else begin
                if (s) begin
                    m_holding  = 1'b1;
                    m_held_ins = imem_rdata;
                    m_held_p4  = m_pc + 32'd4;
                end
                m_pc = m_pc + 32'd4;
            end
        end else if (r) begin
            m_wrong  = 1'b1;
            m_target = tgt;
        end
    endtask

    initial begin
        logic [31:0] held_word;
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        stallf      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        model_reset();

        // Reset state
        #12;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_fvalid", 32'(fvalid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_pcp4f", pcp4f, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait memory: one instruction per cycle from RESET_PC
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            chk("zw_pcp4f", pcp4f, RESET_PC + 32'(4 * (i + 1)));
        end

        // Three-cycle latency at 0x100 (low bits of redirect_pc ignored)
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            chk("lat_addr", imem_addr, 32'h0000_0100);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("lat_pcp4f", pcp4f, 32'h0000_0104);

        // Stall in the ack cycle at 0x200 -> word parked, request dropped
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        held_word = imem_rdata;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        chk("hold_rd", rd, held_word);
        chk("hold_req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("hold_exit_fvalid", 32'(fvalid), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("hold_next_addr", imem_addr, 32'h0000_0204);

        // Two redirects while 0x300 is outstanding; the last one wins
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0500, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0600, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("disc_fvalid", 32'(fvalid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("disc_next_addr", imem_addr, 32'h0000_0600);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pcp4f", pcp4f, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("wrap_addr", imem_addr, 32'd0);

        // Asynchronous reset while a wrong-path request is outstanding
        step(1'b0, 1'b1, 32'h0000_0800, 1'b0);
        #2;
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        redirect = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, RESET_PC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'd0, 1'b0);
        chk("arst_fvalid", 32'(fvalid), 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("arst_first_pcp4f", pcp4f, RESET_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 5) == 0),
                 $urandom,
                 ($urandom_range(0, 1) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
